compare_stream: RTL and testbench
=================================

Name: compare_stream

Overview:
Parametrised, registered successor to the 8-bit combinational equality comparator. Compares two word streams a/b over a frame of frame_len words and produces per-word eq/lt/gt flags one cycle after acceptance. Produces frame-level results: all_equal, mismatch count, and index of the first mismatch. Sits between two data sources, e.g. DUT output vs golden model, as a self-check/verification helper block.

Parameters:
WIDTH, 8, data word width in bits (>=1)
CNT_W, 16, width of frame length, word index and mismatch counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a frame; sampled only in IDLE
frame_len  in  CNT_W  words in frame; sampled with start
signed_mode  in  1  1 = two's-complement lt/gt; sampled with start
in_valid  in  1  a/b word valid
in_ready  out  1  block accepts a word (high only in RUN)
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  per-word result valid, 1 cycle after accept
eq  out  1  registered a==b
lt  out  1  registered a<b (per frame signedness)
gt  out  1  registered a>b
busy  out  1  high in RUN and DONE
done  out  1  single-cycle pulse at frame end
all_equal  out  1  frame had zero mismatches; valid from done, held until next start
mismatch_cnt  out  CNT_W  mismatching words in frame, saturating
first_mismatch_idx  out  CNT_W  index of first mismatch; all-ones if none

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready, out_valid, eq, lt, gt, busy, done = 0; all_equal = 1; mismatch_cnt = 0; first_mismatch_idx = all-ones; word index = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1, frame_len!=0: next state RUN; latch frame_len and signed_mode; clear mismatch_cnt, index, first_mismatch_idx (all-ones); all_equal=1.
- IDLE, start=1, frame_len==0: next state DONE directly; results cleared as above.
- IDLE otherwise: hold. in_valid ignored.
- RUN: in_ready=1. Accept = in_valid & in_ready.
- On accept, next cycle: out_valid=1; eq/lt/gt reflect that word. Exactly one of eq/lt/gt is 1.
- On accept of a mismatch: mismatch_cnt increments, saturating at 2^CNT_W-1. If mismatch_cnt was 0, first_mismatch_idx = current index and all_equal is cleared.
- Index increments per accept. Accepting index frame_len-1 moves to DONE on the next edge.
- Without accept, out_valid=0 and eq/lt/gt hold their last values.
- DONE: one cycle. done=1, in_ready=0, busy=1. The last word's out_valid coincides with done. Next state IDLE.
- start while busy: ignored; latched frame_len and signed_mode are unchanged.
- Arithmetic: unsigned compare by default. With signed_mode, compare $signed operands; eq is unaffected by mode.
- Reset mid-frame: immediate return to reset values; no done pulse.

Optional Feature:
COMPARE_MASK_EN:
- Defined: adds input port mask[WIDTH-1:0]. Bits set to 1 are zeroed in both a and b before all comparisons, including lt/gt.
- Undefined: port absent; all bits compared.

Decomposition:
- Shared package compare_pkg:
  - FSM state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Result code constants for the eq/lt/gt triple.
- One natural sub-module: compare_word. Combinational WIDTH-bit eq/lt/gt with signed_mode input (and the mask under COMPARE_MASK_EN), instantiated once. The top holds the FSM, counters and output registers.

Test Plan:
- Reset: rst_n=0 mid-RUN -> next sample all_equal=1, mismatch_cnt=0, first_mismatch_idx=16'hFFFF, busy=0, no done.
- Equal frame: WIDTH=8, frame_len=3, words (3C,3C),(5A,5A),(00,00) back-to-back -> eq=1 each, done 1 cycle after third accept, all_equal=1, mismatch_cnt=0.
- Mismatch frame: frame_len=4, words (3C,3C),(3C,5A),(BC,5A),(11,11), with in_valid gap on word 2 -> word 1 lt=1; word 2 unsigned gt=1; mismatch_cnt=2, first_mismatch_idx=1, all_equal=0.
- Signed: signed_mode=1, frame_len=1, (BC,5A) -> lt=1, gt=0; same word with signed_mode=0 -> gt=1.
- Zero length plus ignored start: frame_len=0 -> done one cycle after start, no in_ready. start pulsed during RUN of a frame_len=2 frame -> frame length unchanged, single done.
- COMPARE_MASK_EN: mask=8'h0F, (A3,A7) -> eq=1; mask=8'h00 -> lt=1.

Source files
------------

// File: rtl/compare_pkg.sv
// Shared constants for the compare_stream block.
// FSM state encoding and the one-hot {gt, lt, eq} result codes.
// Imported by compare_word and compare_stream.
package compare_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // Result triple packed as {gt, lt, eq}; exactly one bit is ever set.
  localparam logic [2:0] RES_EQ = 3'b001;
  localparam logic [2:0] RES_LT = 3'b010;
  localparam logic [2:0] RES_GT = 3'b100;

endpackage

// File: rtl/compare_word.sv
// Purpose: combinational WIDTH-bit compare of a against b producing one-hot {gt, lt, eq}.
// Latency: zero cycles (pure combinational).
// Backpressure: none; evaluates every cycle.
// Ports: a_i/b_i operands, signed_mode_i selects two's-complement ordering,
//        mask_i (only when COMPARE_MASK_EN is defined) zeroes set bits in both operands,
//        res_o one-hot result code.
module compare_word
  import compare_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_mode_i,
`ifdef COMPARE_MASK_EN
  input  logic [WIDTH-1:0] mask_i,
`endif
  output logic [2:0]       res_o
);

  logic [WIDTH-1:0] a_m;
  logic [WIDTH-1:0] b_m;
  logic             lt_u;
  logic             lt_s;

`ifdef COMPARE_MASK_EN
  // Masked bits are forced to zero before any ordering, so they cannot
  // influence lt/gt either (including the sign bit in signed mode).
  assign a_m = a_i & ~mask_i;
  assign b_m = b_i & ~mask_i;
`else
  assign a_m = a_i;
  assign b_m = b_i;
`endif

  assign lt_u = (a_m < b_m);
  assign lt_s = ($signed(a_m) < $signed(b_m));

  always_comb begin
    res_o = RES_GT;
    if (a_m == b_m) begin
      res_o = RES_EQ;
    end else if (signed_mode_i ? lt_s : lt_u) begin
      res_o = RES_LT;
    end
  end

endmodule

// File: rtl/compare_stream.sv
// Purpose: frame-based a/b stream comparator with per-word eq/lt/gt and frame summary.
// Latency: per-word result one cycle after accept; done pulses with the last word's result.
// Backpressure: in_ready is high for the whole RUN state, so words are never stalled there.
// Ports: clk/rst_n; start, frame_len, signed_mode sampled in IDLE only;
//        in_valid/in_ready/a/b input stream; out_valid/eq/lt/gt per-word result;
//        busy, done, all_equal, mismatch_cnt, first_mismatch_idx frame status.
// Optional: COMPARE_MASK_EN adds input mask; set bits are ignored in both operands.
module compare_stream
  import compare_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             signed_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef COMPARE_MASK_EN
  input  logic [WIDTH-1:0] mask,
`endif
  output logic             out_valid,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic             busy,
  output logic             done,
  output logic             all_equal,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_mismatch_idx
);

  state_e           state_q;
  logic [CNT_W-1:0] len_q;
  logic             smode_q;
  logic [CNT_W-1:0] idx_q;
  logic             out_valid_q;
  logic [2:0]       res_q;
  logic             all_equal_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] first_q;
  logic [2:0]       cmp_res;
  logic             accept;

  // Uses the latched signedness so a mid-frame change on signed_mode is ignored.
  compare_word #(
    .WIDTH(WIDTH)
  ) u_word (
    .a_i          (a),
    .b_i          (b),
    .signed_mode_i(smode_q),
`ifdef COMPARE_MASK_EN
    .mask_i       (mask),
`endif
    .res_o        (cmp_res)
  );

  assign accept = in_valid & (state_q == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      smode_q     <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      all_equal_q <= 1'b1;
      cnt_q       <= '0;
      first_q     <= '1;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q       <= frame_len;
            smode_q     <= signed_mode;
            idx_q       <= '0;
            cnt_q       <= '0;
            first_q     <= '1;
            all_equal_q <= 1'b1;
            // An empty frame skips RUN and reports immediately.
            state_q     <= (frame_len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            out_valid_q <= 1'b1;
            res_q       <= cmp_res;
            idx_q       <= idx_q + 1'b1;
            if (cmp_res != RES_EQ) begin
              if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
              end
              // First mismatch of the frame: cnt_q is still zero here.
              if (cnt_q == '0) begin
                first_q     <= idx_q;
                all_equal_q <= 1'b0;
              end
            end
            if (idx_q == len_q - 1'b1) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Status outputs decode directly from the state flop.
  assign in_ready           = (state_q == S_RUN);
  assign busy               = (state_q != S_IDLE);
  assign done               = (state_q == S_DONE);
  assign out_valid          = out_valid_q;
  assign eq                 = res_q[0];
  assign lt                 = res_q[1];
  assign gt                 = res_q[2];
  assign all_equal          = all_equal_q;
  assign mismatch_cnt       = cnt_q;
  assign first_mismatch_idx = first_q;

endmodule

// File: tb/tb_compare_stream.sv
module tb_compare_stream;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] frame_len;
  logic             signed_mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] mask;
  logic             out_valid;
  logic             eq;
  logic             lt;
  logic             gt;
  logic             busy;
  logic             done;
  logic             all_equal;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CNT_W-1:0] first_mismatch_idx;

  int total = 0;
  int bad   = 0;

  // Frame stimulus and what the driver observed.
  logic [7:0] wa [64];
  logic [7:0] wb [64];
  logic [2:0] obs_res [$];
  int         obs_done_cnt;
  int         obs_done_cyc;
  int         obs_last_drive_cyc;
  logic       obs_ov_at_done;
  logic       obs_ready_seen;

  compare_stream #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .frame_len         (frame_len),
    .signed_mode       (signed_mode),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .a                 (a),
    .b                 (b),
`ifdef COMPARE_MASK_EN
    .mask              (mask),
`endif
    .out_valid         (out_valid),
    .eq                (eq),
    .lt                (lt),
    .gt                (gt),
    .busy              (busy),
    .done              (done),
    .all_equal         (all_equal),
    .mismatch_cnt      (mismatch_cnt),
    .first_mismatch_idx(first_mismatch_idx)
  );

  always #5 clk = ~clk;

  // Reference: compare as integers, sign-extending by hand in signed mode.
  function automatic logic [2:0] ref_cmp(input logic [7:0] x, input logic [7:0] y,
                                         input logic sm, input logic [7:0] m);
    logic [7:0] xm;
    logic [7:0] ym;
    int xi;
    int yi;
    xm = x & ~m;
    ym = y & ~m;
    xi = int'(xm);
    yi = int'(ym);
    if (sm) begin
      if (xi >= 128) xi = xi - 256;
      if (yi >= 128) yi = yi - 256;
    end
    if (xi == yi) return 3'b001;
    if (xi < yi) return 3'b010;
    return 3'b100;
  endfunction

  // Drives one frame (n words from wa/wb) and records what comes back.
  task automatic run_frame(input int n, input logic [15:0] len, input logic sm,
                           input int gap_at, input int gap_pct, input int start_mid_at);
    int  sent;
    bit  gapped;
    obs_res.delete();
    obs_done_cnt       = 0;
    obs_done_cyc       = -1;
    obs_last_drive_cyc = -1;
    obs_ov_at_done     = 1'b0;
    obs_ready_seen     = 1'b0;
    @(negedge clk);
    start       = 1'b1;
    frame_len   = len;
    signed_mode = sm;
    @(negedge clk);
    start       = 1'b0;
    frame_len   = 16'd9;
    signed_mode = ~sm;
    sent   = 0;
    gapped = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (in_ready) obs_ready_seen = 1'b1;
      if (out_valid) obs_res.push_back({gt, lt, eq});
      if (done) begin
        obs_done_cnt++;
        if (obs_done_cyc < 0) begin
          obs_done_cyc   = cyc;
          obs_ov_at_done = out_valid;
        end
      end
      if (obs_done_cyc >= 0 && cyc >= obs_done_cyc + 3) break;
      start     = (cyc == start_mid_at);
      frame_len = (cyc == start_mid_at) ? 16'd7 : 16'd9;
      in_valid  = 1'b0;
      a         = 8'($urandom);
      b         = 8'($urandom);
      if (sent < n) begin
        if (sent == gap_at && !gapped) begin
          gapped = 1;
        end else if (int'($urandom_range(0, 99)) >= gap_pct) begin
          in_valid = 1'b1;
          a        = wa[sent];
          b        = wb[sent];
          if (in_ready) begin
            sent++;
            obs_last_drive_cyc = cyc;
          end
        end
      end
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; frame_len = '0; signed_mode = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; mask = '0;
    #12;
    total++;
    if ({in_ready, out_valid, eq, lt, gt, busy, done} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0000000", {in_ready, out_valid, eq, lt, gt, busy, done});
    end
    total++;
    if ({all_equal, mismatch_cnt, first_mismatch_idx} !== {1'b1, 16'h0000, 16'hFFFF}) begin
      bad++;
      $display("FAIL reset_results got=%b/%h/%h want=1/0000/ffff", all_equal, mismatch_cnt, first_mismatch_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Mid-frame reset.
    @(negedge clk);
    start = 1'b1; frame_len = 16'd5;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; a = 8'h01; b = 8'h02;
    @(negedge clk);
    a = 8'h03; b = 8'h03;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (mismatch_cnt !== 16'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_run got cnt=%h busy=%b want cnt=0001 busy=1", mismatch_cnt, busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({all_equal, mismatch_cnt, first_mismatch_idx, busy, done, out_valid} !==
        {1'b1, 16'h0000, 16'hFFFF, 3'b000}) begin
      bad++;
      $display("FAIL midrun_reset got ae=%b cnt=%h first=%h busy=%b done=%b ov=%b want 1/0000/ffff/0/0/0",
               all_equal, mismatch_cnt, first_mismatch_idx, busy, done, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_done got=%b want=0", done);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_equal_frame();
    logic [2:0] r;
    wa[0] = 8'h3C; wb[0] = 8'h3C;
    wa[1] = 8'h5A; wb[1] = 8'h5A;
    wa[2] = 8'h00; wb[2] = 8'h00;
    run_frame(3, 16'd3, 1'b0, -1, 0, -1);
    total++;
    if (obs_res.size() !== 3) begin
      bad++;
      $display("FAIL eqf_count got=%0d want=3", obs_res.size());
    end
    for (int i = 0; i < 3 && i < obs_res.size(); i++) begin
      r = obs_res[i];
      total++;
      if (r !== 3'b001) begin
        bad++;
        $display("FAIL eqf_word%0d got=%b want=001", i, r);
      end
    end
    total++;
    if (obs_done_cyc !== obs_last_drive_cyc + 1 || obs_ov_at_done !== 1'b1 || obs_done_cnt !== 1) begin
      bad++;
      $display("FAIL eqf_done got cyc=%0d ov=%b n=%0d want cyc=%0d ov=1 n=1",
               obs_done_cyc, obs_ov_at_done, obs_done_cnt, obs_last_drive_cyc + 1);
    end
    total++;
    if ({all_equal, mismatch_cnt, first_mismatch_idx} !== {1'b1, 16'h0000, 16'hFFFF}) begin
      bad++;
      $display("FAIL eqf_results got=%b/%h/%h want=1/0000/ffff", all_equal, mismatch_cnt, first_mismatch_idx);
    end
  endtask

  task automatic test_mismatch_frame();
    logic [2:0] want [4];
    logic [2:0] r;
    wa[0] = 8'h3C; wb[0] = 8'h3C; want[0] = 3'b001;
    wa[1] = 8'h3C; wb[1] = 8'h5A; want[1] = 3'b010;
    wa[2] = 8'hBC; wb[2] = 8'h5A; want[2] = 3'b100;
    wa[3] = 8'h11; wb[3] = 8'h11; want[3] = 3'b001;
    run_frame(4, 16'd4, 1'b0, 2, 0, -1);
    total++;
    if (obs_res.size() !== 4) begin
      bad++;
      $display("FAIL mmf_count got=%0d want=4", obs_res.size());
    end
    for (int i = 0; i < 4 && i < obs_res.size(); i++) begin
      r = obs_res[i];
      total++;
      if (r !== want[i]) begin
        bad++;
        $display("FAIL mmf_word%0d got=%b want=%b", i, r, want[i]);
      end
    end
    total++;
    if ({all_equal, mismatch_cnt, first_mismatch_idx} !== {1'b0, 16'd2, 16'd1}) begin
      bad++;
      $display("FAIL mmf_results got=%b/%h/%h want=0/0002/0001", all_equal, mismatch_cnt, first_mismatch_idx);
    end
  endtask

  task automatic test_signed();
    logic [2:0] r;
    wa[0] = 8'hBC; wb[0] = 8'h5A;
    for (int m = 1; m >= 0; m--) begin
      run_frame(1, 16'd1, 1'(m), -1, 0, -1);
      r = (obs_res.size() > 0) ? obs_res[0] : 3'bxxx;
      total++;
      if (r !== ((m == 1) ? 3'b010 : 3'b100)) begin
        bad++;
        $display("FAIL signed_mode%0d got=%b want=%b", m, r, (m == 1) ? 3'b010 : 3'b100);
      end
    end
  endtask

  task automatic test_zero_len();
    run_frame(0, 16'd0, 1'b0, -1, 0, -1);
    total++;
    if (obs_done_cyc !== 0 || obs_ready_seen !== 1'b0 || obs_done_cnt !== 1) begin
      bad++;
      $display("FAIL zero_len got cyc=%0d ready=%b n=%0d want cyc=0 ready=0 n=1",
               obs_done_cyc, obs_ready_seen, obs_done_cnt);
    end
    total++;
    if ({all_equal, mismatch_cnt, first_mismatch_idx} !== {1'b1, 16'h0000, 16'hFFFF}) begin
      bad++;
      $display("FAIL zero_results got=%b/%h/%h want=1/0000/ffff", all_equal, mismatch_cnt, first_mismatch_idx);
    end
  endtask

  task automatic test_ignored_start();
    wa[0] = 8'h10; wb[0] = 8'h10;
    wa[1] = 8'h20; wb[1] = 8'h21;
    run_frame(2, 16'd2, 1'b0, -1, 0, 0);
    total++;
    if (obs_done_cnt !== 1 || obs_res.size() !== 2 || obs_done_cyc !== obs_last_drive_cyc + 1) begin
      bad++;
      $display("FAIL ignored_start got dones=%0d words=%0d cyc=%0d want 1/2/%0d",
               obs_done_cnt, obs_res.size(), obs_done_cyc, obs_last_drive_cyc + 1);
    end
    total++;
    if ({mismatch_cnt, first_mismatch_idx} !== {16'd1, 16'd1}) begin
      bad++;
      $display("FAIL ignored_start_res got=%h/%h want=0001/0001", mismatch_cnt, first_mismatch_idx);
    end
  endtask

  task automatic test_random();
    int         n;
    logic       sm;
    logic [2:0] want;
    int         exp_cnt;
    int         exp_first;
    for (int f = 0; f < 30; f++) begin
      n  = int'($urandom_range(1, 12));
      sm = 1'($urandom);
      for (int i = 0; i < n; i++) begin
        wa[i] = 8'($urandom);
        wb[i] = ($urandom_range(0, 1) == 0) ? wa[i] : 8'($urandom);
      end
      run_frame(n, 16'(n), sm, -1, 30, -1);
      exp_cnt   = 0;
      exp_first = 16'hFFFF;
      total++;
      if (obs_res.size() !== n || obs_done_cnt !== 1 || obs_done_cyc !== obs_last_drive_cyc + 1) begin
        bad++;
        $display("FAIL rnd%0d_frame got words=%0d dones=%0d cyc=%0d want %0d/1/%0d",
                 f, obs_res.size(), obs_done_cnt, obs_done_cyc, n, obs_last_drive_cyc + 1);
      end
      for (int i = 0; i < n; i++) begin
        want = ref_cmp(wa[i], wb[i], sm, 8'h00);
        if (want != 3'b001) begin
          if (exp_cnt == 0) exp_first = i;
          exp_cnt++;
        end
        if (i < obs_res.size()) begin
          total++;
          if (obs_res[i] !== want) begin
            bad++;
            $display("FAIL rnd%0d_word%0d a=%h b=%h sm=%b got=%b want=%b", f, i, wa[i], wb[i], sm, obs_res[i], want);
          end
        end
      end
      total++;
      if ({all_equal, mismatch_cnt, first_mismatch_idx} !== {(exp_cnt == 0), 16'(exp_cnt), 16'(exp_first)}) begin
        bad++;
        $display("FAIL rnd%0d_results got=%b/%h/%h want=%b/%h/%h", f, all_equal, mismatch_cnt,
                 first_mismatch_idx, (exp_cnt == 0), 16'(exp_cnt), 16'(exp_first));
      end
    end
  endtask

`ifdef COMPARE_MASK_EN
  task automatic test_mask();
    logic [2:0] r;
    wa[0] = 8'hA3; wb[0] = 8'hA7;
    mask = 8'h0F;
    run_frame(1, 16'd1, 1'b0, -1, 0, -1);
    r = (obs_res.size() > 0) ? obs_res[0] : 3'bxxx;
    total++;
    if (r !== 3'b001) begin
      bad++;
      $display("FAIL mask_0f got=%b want=001", r);
    end
    mask = 8'h00;
    run_frame(1, 16'd1, 1'b0, -1, 0, -1);
    r = (obs_res.size() > 0) ? obs_res[0] : 3'bxxx;
    total++;
    if (r !== 3'b010) begin
      bad++;
      $display("FAIL mask_00 got=%b want=010", r);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_equal_frame();
    test_mismatch_frame();
    test_signed();
    test_zero_len();
    test_ignored_start();
    test_random();
`ifdef COMPARE_MASK_EN
    test_mask();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
